psad_min_collector: RTL and testbench
=====================================

Name: psad_min_collector

Overview:
- Downstream consumer of the partial-SAD (psad) addend stream produced by the AD systolic array.
- For each current block it sums the EDGE_LEN column-lane partial SADs of every candidate into a full SAD, across NUM_BATCHES batches of PIXELS_IN_BATCH candidates.
- Tracks the minimum SAD and its candidate index.
- Hands the winning result to the motion-vector stage over a valid/ready handshake.

Parameters:
- PIXELS_IN_BATCH, 16, candidates delivered per beat
- EDGE_LEN, 8, column lanes per beat (block edge length)
- PSAD_BIT_WIDTH, 11, width of one lane addend (unsigned)
- NUM_BATCHES, 16, beats per search window
- SAD_WIDTH, PSAD_BIT_WIDTH+$clog2(EDGE_LEN), full SAD width
- IDX_WIDTH, $clog2(NUM_BATCHES*PIXELS_IN_BATCH), candidate index width

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse; begins a search window
- addend_valid  input  1  psad_addend_batch carries a valid beat
- psad_addend_batch  input  PSAD_BIT_WIDTH*EDGE_LEN*PIXELS_IN_BATCH  lane (c,p) at bits [(c*PIXELS_IN_BATCH+p+1)*PSAD_BIT_WIDTH-1 : (c*PIXELS_IN_BATCH+p)*PSAD_BIT_WIDTH]
- result_ready  input  1  consumer accepts result
- busy  output  1  state != IDLE
- result_valid  output  1  best_sad/best_index valid
- best_sad  output  SAD_WIDTH  minimum SAD of the window
- best_index  output  IDX_WIDTH  batch*PIXELS_IN_BATCH+p of the minimum

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; busy=0, result_valid=0, best_sad=0, best_index=0; beat counter=0; pipeline valids=0; internal running minimum=all-ones.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 -> RUN; clears the beat counter; running minimum=all-ones; running index=0.
  - addend_valid is ignored.
- RUN:
  - Each cycle with addend_valid=1 is one accepted beat; the beat counter increments.
  - The beat accepted with counter=NUM_BATCHES-1 -> DRAIN.
  - start is ignored.
  - Gaps (addend_valid=0) are allowed and have no effect.
- Pipeline stage 1, registered at T+1 for a beat accepted at T:
  - sum[p] = sum over c of lane(c,p), zero-extended to SAD_WIDTH. No overflow is possible.
  - The batch number is also registered.
- Pipeline stage 2, registered at T+2:
  - Scans p=0..PIXELS_IN_BATCH-1 in ascending order with strict less-than, giving the batch minimum with the lowest p winning ties.
  - Updates the running minimum only if the batch minimum is strictly less than it, so earlier batches win ties.
  - Net effect: the lowest overall index wins any tie.
- DRAIN: waits until both pipeline valids are 0, then -> DONE. The result is registered into best_sad/best_index.
- result_valid rises exactly 3 cycles after the final beat's accept cycle T, i.e. it is high in cycle T+3.
- DONE:
  - result_valid=1; best_sad/best_index held stable.
  - On result_valid&&result_ready -> IDLE and result_valid drops next cycle; best_sad/best_index keep their last value.
  - start is ignored, including in the handshake cycle. A new window needs start while in IDLE.
  - addend_valid is ignored.
- addend_valid outside RUN never enters the pipeline.
- Reset mid-operation: immediate return to the reset values; the partial window is discarded. No output glitch after reset deasserts.

Test Plan:
- Window isolation: start; 16 beats, all lanes=10 except batch 5 p=3, all c lanes=2 -> best_sad=16, best_index=83; result_valid high exactly 3 cycles after beat 16; busy high from the cycle after start.
- Tie-break:
  - All lanes=7 -> best_sad=56, best_index=0.
  - Then only candidates 40 and 200 have all lanes=1 -> best_index=40, best_sad=8.
- Width limit:
  - All lanes=2040 -> best_sad=16320, best_index=0, no wrap.
  - Then all lanes=2040 except batch 15 p=15 c=0 lane=2039 -> best_sad=16319, best_index=255.
- Bubbles and stray valids:
  - Scenario 1 repeated with random addend_valid gaps -> identical result.
  - Beats with addend_valid=1 presented in IDLE or DONE -> no effect on the next window's result.
- Backpressure:
  - result_ready held low 10 cycles -> result_valid and outputs stable.
  - start pulsed during DONE -> ignored.
  - ready=1 -> result_valid=0 and busy=0 next cycle.
  - A fresh start then yields a correct new window.
- Reset mid-RUN after 7 beats -> busy=0, result_valid=0 asynchronously; a following start plus 16 beats yields the correct result, uncontaminated by the aborted beats.

Source files
------------

// File: rtl/psad_min_collector.sv
`default_nettype none
// psad_min_collector: sums per-candidate partial SADs over a search window and reports the minimum SAD and its index.
// Rev 1.0
module psad_min_collector #(
   parameter int PIXELS_IN_BATCH = 16,
   parameter int EDGE_LEN        = 8,
   parameter int PSAD_BIT_WIDTH  = 11,
   parameter int NUM_BATCHES     = 16,
   parameter int SAD_WIDTH       = PSAD_BIT_WIDTH + $clog2(EDGE_LEN),
   parameter int IDX_WIDTH       = $clog2(NUM_BATCHES * PIXELS_IN_BATCH)
) (
   input  logic                                          clk,
   input  logic                                          rst,
   input  logic                                          start,
   input  logic                                          addend_valid,
   input  logic [PSAD_BIT_WIDTH*EDGE_LEN*PIXELS_IN_BATCH-1:0] psad_addend_batch,
   input  logic                                          result_ready,
   output logic                                          busy,
   output logic                                          result_valid,
   output logic [SAD_WIDTH-1:0]                          best_sad,
   output logic [IDX_WIDTH-1:0]                          best_index
);

   localparam int BATCH_W = (NUM_BATCHES > 1) ? $clog2(NUM_BATCHES) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t               state;
   logic [BATCH_W-1:0]   beat_cnt;
   logic                 accept;

   logic                 s1_valid;
   logic [BATCH_W-1:0]   s1_batch;
   logic [SAD_WIDTH-1:0] s1_sum  [PIXELS_IN_BATCH];
   logic [SAD_WIDTH-1:0] lane_sum[PIXELS_IN_BATCH];

   logic [SAD_WIDTH-1:0] batch_min;
   logic [IDX_WIDTH-1:0] batch_idx;
   logic [SAD_WIDTH-1:0] run_min;
   logic [IDX_WIDTH-1:0] run_idx;

   assign accept = (state == RUN) && addend_valid;

   always_comb begin
      for (int p = 0; p < PIXELS_IN_BATCH; p++) begin
         lane_sum[p] = '0;
         for (int c = 0; c < EDGE_LEN; c++) begin
            lane_sum[p] = lane_sum[p] + SAD_WIDTH'(psad_addend_batch[(c*PIXELS_IN_BATCH+p)*PSAD_BIT_WIDTH +: PSAD_BIT_WIDTH]);
         end
      end
   end

   // Strict less-than in ascending p keeps the lowest candidate on ties.
   always_comb begin
      batch_min = s1_sum[0];
      batch_idx = IDX_WIDTH'(s1_batch) * IDX_WIDTH'(PIXELS_IN_BATCH);
      for (int p = 1; p < PIXELS_IN_BATCH; p++) begin
         if (s1_sum[p] < batch_min) begin
            batch_min = s1_sum[p];
            batch_idx = IDX_WIDTH'(s1_batch) * IDX_WIDTH'(PIXELS_IN_BATCH) + IDX_WIDTH'(p);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         s1_sum <= lane_sum;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_batch <= '0;
      end else begin
         s1_valid <= accept;
         if (accept) begin
            s1_batch <= beat_cnt;
         end
      end
   end

   // Running minimum: an earlier batch keeps the win on an equal SAD.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         run_min <= '1;
         run_idx <= '0;
      end else if (state == IDLE && start) begin
         run_min <= '1;
         run_idx <= '0;
      end else if (s1_valid && (batch_min < run_min)) begin
         run_min <= batch_min;
         run_idx <= batch_idx;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         busy         <= 1'b0;
         result_valid <= 1'b0;
         best_sad     <= '0;
         best_index   <= '0;
         beat_cnt     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state    <= RUN;
                  busy     <= 1'b1;
                  beat_cnt <= '0;
               end
            end
            RUN: begin
               if (addend_valid) begin
                  beat_cnt <= beat_cnt + BATCH_W'(1);
                  if (beat_cnt == BATCH_W'(NUM_BATCHES - 1)) begin
                     state <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               // Stage-2 registers already hold the final minimum once stage 1 is empty.
               if (!s1_valid) begin
                  state        <= DONE;
                  result_valid <= 1'b1;
                  best_sad     <= run_min;
                  best_index   <= run_idx;
               end
            end
            DONE: begin
               if (result_ready) begin
                  state        <= IDLE;
                  busy         <= 1'b0;
                  result_valid <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_psad_min_collector.sv
`default_nettype none
// tb_psad_min_collector: directed self-checking bench for psad_min_collector.
// Rev 1.0
module tb_psad_min_collector;

   localparam int P   = 16;
   localparam int E   = 8;
   localparam int W   = 11;
   localparam int NB  = 16;
   localparam int SW  = 14;
   localparam int IW  = 8;
   localparam int BUS = W * E * P;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           start = 1'b0;
   logic           addend_valid = 1'b0;
   logic [BUS-1:0] psad_addend_batch = '0;
   logic           result_ready = 1'b0;
   logic           busy;
   logic           result_valid;
   logic [SW-1:0]  best_sad;
   logic [IW-1:0]  best_index;

   int n_cmp = 0;
   int n_err = 0;

   logic [W-1:0] lane_val [NB][P][E];

   psad_min_collector dut (
      .clk               (clk),
      .rst               (rst),
      .start             (start),
      .addend_valid      (addend_valid),
      .psad_addend_batch (psad_addend_batch),
      .result_ready      (result_ready),
      .busy              (busy),
      .result_valid      (result_valid),
      .best_sad          (best_sad),
      .best_index        (best_index)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fill(input int v);
      for (int b = 0; b < NB; b++)
         for (int p = 0; p < P; p++)
            for (int c = 0; c < E; c++)
               lane_val[b][p][c] = W'(v);
   endtask

   task automatic set_cand(input int idx, input int v);
      for (int c = 0; c < E; c++)
         lane_val[idx / P][idx % P][c] = W'(v);
   endtask

   function automatic logic [BUS-1:0] pack(input int b);
      logic [BUS-1:0] r;
      r = '0;
      for (int c = 0; c < E; c++)
         for (int p = 0; p < P; p++)
            r[(c*P+p)*W +: W] = lane_val[b][p][c];
      return r;
   endfunction

   // Stray zero beats in IDLE (including the start cycle) and in DONE would pull the minimum to 0 if they leaked.
   task automatic run_window(input string nm, input int exp_sad, input int exp_idx,
                             input bit gaps, input int hold);
      psad_addend_batch = '0;
      addend_valid = 1'b1;
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      addend_valid = 1'b0;
      chk({nm, "_busy_after_start"}, 32'(busy), 32'd1);
      for (int b = 0; b < NB; b++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 3)) begin
               addend_valid = 1'b0;
               psad_addend_batch = '0;
               tick();
            end
         end
         psad_addend_batch = pack(b);
         addend_valid = 1'b1;
         tick();
      end
      addend_valid = 1'b0;
      psad_addend_batch = '0;
      chk({nm, "_rv_T+1"}, 32'(result_valid), 32'd0);
      tick();
      chk({nm, "_rv_T+2"}, 32'(result_valid), 32'd0);
      tick();
      chk({nm, "_rv_T+3"}, 32'(result_valid), 32'd1);
      chk({nm, "_sad"}, 32'(best_sad), 32'(exp_sad));
      chk({nm, "_idx"}, 32'(best_index), 32'(exp_idx));
      for (int h = 0; h < hold; h++) begin
         addend_valid = 1'b1;
         start = (h == 1);
         tick();
         chk({nm, "_hold_rv"}, 32'(result_valid), 32'd1);
         chk({nm, "_hold_busy"}, 32'(busy), 32'd1);
         chk({nm, "_hold_sad"}, 32'(best_sad), 32'(exp_sad));
         chk({nm, "_hold_idx"}, 32'(best_index), 32'(exp_idx));
      end
      start = 1'b1;
      result_ready = 1'b1;
      addend_valid = 1'b0;
      tick();
      start = 1'b0;
      result_ready = 1'b0;
      chk({nm, "_rv_after_hs"}, 32'(result_valid), 32'd0);
      chk({nm, "_busy_after_hs"}, 32'(busy), 32'd0);
      chk({nm, "_sad_kept"}, 32'(best_sad), 32'(exp_sad));
      chk({nm, "_idx_kept"}, 32'(best_index), 32'(exp_idx));
   endtask

   initial begin
      repeat (3) tick();
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_rv", 32'(result_valid), 32'd0);
      chk("reset_sad", 32'(best_sad), 32'd0);
      chk("reset_idx", 32'(best_index), 32'd0);
      rst = 1'b0;
      tick();

      // Batch 5, p 3 sums to 2*8 = 16, index 5*16+3 = 83; everything else 80.
      fill(10);
      set_cand(83, 2);
      run_window("iso", 16, 83, 1'b0, 3);

      fill(7);
      run_window("tie_all", 56, 0, 1'b0, 2);

      fill(7);
      set_cand(40, 1);
      set_cand(200, 1);
      run_window("tie_pair", 8, 40, 1'b0, 2);

      fill(2040);
      run_window("width_max", 16320, 0, 1'b0, 2);

      fill(2040);
      lane_val[15][15][0] = W'(2039);
      run_window("width_last", 16319, 255, 1'b0, 2);

      fill(10);
      set_cand(83, 2);
      run_window("gaps_bp", 16, 83, 1'b1, 10);

      // Abort a window after 7 all-zero beats.
      fill(0);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int b = 0; b < 7; b++) begin
         psad_addend_batch = pack(b);
         addend_valid = 1'b1;
         tick();
      end
      addend_valid = 1'b0;
      psad_addend_batch = '0;
      #2 rst = 1'b1;
      #1;
      chk("async_rst_busy", 32'(busy), 32'd0);
      chk("async_rst_rv", 32'(result_valid), 32'd0);
      chk("async_rst_sad", 32'(best_sad), 32'd0);
      tick();
      rst = 1'b0;
      tick();
      chk("post_rst_busy", 32'(busy), 32'd0);

      fill(10);
      set_cand(83, 2);
      run_window("after_rst", 16, 83, 1'b0, 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
